// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the free-running refclk: pulses pll_rst, waits for a
// synchronized lock, qualifies it for STABLE_CYCLES, and supervises lock while running.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7,
  parameter int CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       pll_ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } st_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  st_t              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_d;
  logic [7:0]       lost_d;
  logic [1:0]       rst_sync;
  logic [1:0]       lk_sync;
  logic             run_en;
  logic             lk_s;

  // Assertion is immediate; release only takes effect after two refclk edges.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) lk_sync <= 2'b00;
    else        lk_sync <= {lk_sync[0], locked};
  end

  assign run_en = rst_sync[1];
  assign lk_s   = lk_sync[1];

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    retry_d = retry_cnt;
    lost_d  = lost_cnt;
    if (restart) begin
      st_d    = S_RESET;
      cnt_d   = '0;
      retry_d = 4'd0;
    end else begin
      case (st_q)
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            st_d  = S_WAIT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (lk_s) begin
            st_d  = S_STABLE;
            cnt_d = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_cnt == RETRY_MAX) begin
              st_d = S_FAIL;
            end else begin
              st_d    = S_RESET;
              retry_d = retry_cnt + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          // A dropout here is a glitch, not a failed attempt.
          if (!lk_s) begin
            st_d  = S_WAIT;
            cnt_d = '0;
          end else if (cnt_q == STABLE_LAST) begin
            st_d    = S_RUN;
            cnt_d   = '0;
            retry_d = 4'd0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            st_d   = S_RESET;
            cnt_d  = '0;
            lost_d = (lost_cnt == 8'hFF) ? lost_cnt : lost_cnt + 8'd1;
          end
        end
        S_FAIL:  st_d = S_FAIL;
        default: begin
          st_d  = S_RESET;
          cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_RESET;
      cnt_q     <= '0;
      retry_cnt <= 4'd0;
      lost_cnt  <= 8'd0;
      pll_rst   <= 1'b1;
      pll_ready <= 1'b0;
      fail      <= 1'b0;
    end else if (run_en) begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      lost_cnt  <= lost_d;
      pll_rst   <= (st_d == S_RESET) || (st_d == S_FAIL);
      pll_ready <= (st_d == S_RUN);
      fail      <= (st_d == S_FAIL);
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed sequence with randomized lock timing; expectations come from the
// timing rules (sync latency, cycle counts, retry/lost bookkeeping).
module tb_pll_reset_sequencer;

  localparam int RST = 4;
  localparam int TO  = 20;
  localparam int STB = 8;
  localparam int MR  = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, pll_ready, fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic       b_pll_rst, b_pll_ready, b_fail;
  logic [2:0] b_state;
  logic [3:0] b_retry_cnt;
  logic [7:0] b_lost_cnt;

  int total = 0;
  int bad = 0;
  int n, hi, k, runs, exp_lost, ok;
  int run_len[8];
  int gap_len[8];
  int run_retry[8];
  logic saw1, saw2, early;
  logic [2:0] prev;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(.RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB),
                        .MAX_RETRY(MR), .CNT_W(16)) u_dut (
    .refclk(refclk), .rst_n(rst_n), .locked(locked), .restart(restart),
    .pll_rst(pll_rst), .pll_ready(pll_ready), .fail(fail), .state(state),
    .retry_cnt(retry_cnt), .lost_cnt(lost_cnt));

  // Larger retry budget so retry_cnt can reach 3 before the async reset check.
  pll_reset_sequencer #(.RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB),
                        .MAX_RETRY(4), .CNT_W(16)) u_dut_b (
    .refclk(refclk), .rst_n(rst_n), .locked(locked), .restart(restart),
    .pll_rst(b_pll_rst), .pll_ready(b_pll_ready), .fail(b_fail), .state(b_state),
    .retry_cnt(b_retry_cnt), .lost_cnt(b_lost_cnt));

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    exp_lost = 0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_ready", pll_ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_lost", lost_cnt, 0);

    // Two sync edges, then RST edges in RESET; the last of those drops pll_rst.
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!pll_rst) break;
      hi++;
    end
    chk("pwrup_rst_len", hi, 2 + RST - 1);

    // Lock latency: 2 sync edges, 1 edge leaving WAIT_LOCK, then STB qualify edges.
    k = $urandom_range(1, 6);
    repeat (k) tick();
    locked = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick(); n++;
      if (pll_ready) break;
    end
    chk("pwrup_lock_lat", n, 3 + STB);
    chk("pwrup_state", state, 3);
    chk("pwrup_retry", retry_cnt, 0);

    // Restart from RUN, then a one-cycle dropout while qualifying.
    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_run_state", state, 0);
    chk("restart_run_lost", lost_cnt, exp_lost);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (state == 3'd2) begin ok = 1; break; end
    end
    chk("reach_stable", ok, 1);
    k = $urandom_range(0, 4);
    repeat (k) tick();
    locked = 1'b0; tick(); locked = 1'b1;
    n = 0; saw1 = 1'b0; saw2 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(); n++;
      if (state == 3'd1) saw1 = 1'b1;
      if (saw1 && state == 3'd2) saw2 = 1'b1;
      if (pll_ready) break;
    end
    chk("glitch_to_wait", saw1, 1);
    chk("glitch_to_stable", saw2, 1);
    chk("glitch_relock_lat", n, 3 + STB);
    chk("glitch_retry", retry_cnt, 0);

    // Restart on the same edge that would register a lock loss: no loss counted.
    locked = 1'b0; tick(); tick();
    restart = 1'b1; tick(); restart = 1'b0;
    chk("coinc_state", state, 0);
    chk("coinc_lost", lost_cnt, exp_lost);
    chk("coinc_retry", retry_cnt, 0);
    chk("coinc_fail", fail, 0);
    locked = 1'b1;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (pll_ready) begin ok = 1; break; end
    end
    chk("coinc_relock", ok, 1);

    // Repeated lock loss; lost_cnt must saturate.
    for (int it = 0; it < 300; it++) begin
      locked = 1'b0;
      n = 0; early = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick(); n++;
        if (pll_rst) break;
        if (!pll_ready) early = 1'b1;
      end
      exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
      chk("loss_lat", n, 3);
      chk("loss_ready_same_edge", pll_ready, 0);
      chk("loss_no_early_drop", early, 0);
      chk("loss_lost_cnt", lost_cnt, exp_lost);
      repeat ($urandom_range(0, 3)) tick();
      locked = 1'b1;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (pll_ready) begin ok = 1; break; end
      end
      chk("loss_relock", ok, 1);
    end
    chk("lost_saturated", lost_cnt, 255);

    // No lock at all: MR+1 reset pulses, then FAIL.
    restart = 1'b1; locked = 1'b0; tick(); restart = 1'b0;
    runs = 0; prev = 3'd7;
    for (int j = 0; j < 8; j++) begin run_len[j] = 0; gap_len[j] = 0; run_retry[j] = -1; end
    for (int i = 0; i < 300; i++) begin
      if (state == 3'd0) begin
        if (prev != 3'd0 && runs < 8) begin run_retry[runs] = int'(retry_cnt); runs++; end
        if (runs > 0) run_len[runs-1]++;
      end else if (state == 3'd1 && runs > 0) begin
        gap_len[runs-1]++;
      end
      if (fail) break;
      prev = state;
      tick();
    end
    chk("fail_pulses", runs, MR + 1);
    for (int j = 0; j <= MR; j++) begin
      chk("fail_pulse_len", run_len[j], RST);
      chk("fail_wait_len", gap_len[j], TO);
      chk("fail_pulse_retry", run_retry[j], j);
    end
    chk("fail_flag", fail, 1);
    chk("fail_state", state, 4);
    chk("fail_pll_rst", pll_rst, 1);
    chk("fail_retry", retry_cnt, MR);
    repeat (30) tick();
    chk("fail_hold_state", state, 4);
    chk("fail_hold_pll_rst", pll_rst, 1);

    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_fail_state", state, 0);
    chk("restart_fail_retry", retry_cnt, 0);
    chk("restart_fail_flag", fail, 0);
    chk("restart_fail_pll_rst", pll_rst, 1);

    // Async reset in WAIT_LOCK with retry_cnt=3 (second instance).
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (b_state == 3'd1 && b_retry_cnt == 4'd3) begin ok = 1; break; end
    end
    chk("b_reach_retry3", ok, 1);
    repeat (3) tick();
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_b_state", b_state, 0);
    chk("async_b_pll_rst", b_pll_rst, 1);
    chk("async_b_retry", b_retry_cnt, 0);
    chk("async_b_lost", b_lost_cnt, 0);
    chk("async_b_fail", b_fail, 0);
    chk("async_b_ready", b_pll_ready, 0);
    chk("async_lost", lost_cnt, 0);
    chk("async_state", state, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
